// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: round-robin grant, a fixed number of bus cycles per
// transfer, then a one-cycle ack carrying the captured read data and exception.
module dbus_arbiter #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [1:0]  m0_len,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_exc,

    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [1:0]  m1_len,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_exc,

    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write,
    input  logic [31:0] bus_read,
    input  logic        bus_exception,

    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a master raises req with its fields and holds them until its
    // one-cycle ack; the request is accepted when req is seen in IDLE, after which
    // field changes or a dropped req no longer affect the transfer in flight.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic        last_q;   // 1 = m1 was granted last
    logic        gnt_q;    // 1 = m1 owns the current transfer
    logic        pick_m1;
    logic        any_req;

    logic        lat_rw;
    logic [1:0]  lat_len;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    assign any_req = m0_req | m1_req;

    always_comb begin
        pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
            pick_m1 = ~last_q;
        end else if (m1_req) begin
            pick_m1 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            lat_rw    <= 1'b0;
            lat_len   <= 2'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
            m0_exc    <= 1'b0;
            m1_exc    <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q     <= pick_m1;
                        cnt_q     <= CNT_INIT;
                        lat_rw    <= pick_m1 ? m1_rw    : m0_rw;
                        lat_len   <= pick_m1 ? m1_len   : m0_len;
                        lat_addr  <= pick_m1 ? m1_addr  : m0_addr;
                        lat_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (gnt_q) begin
                        m1_rdata <= bus_read;
                        m1_exc   <= bus_exception;
                    end else begin
                        m0_rdata <= bus_read;
                        m0_exc   <= bus_exception;
                    end
                end
                RESP: begin
                    // Ack is registered here, so it appears in the first IDLE cycle.
                    if (gnt_q) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    last_q <= gnt_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Bus is driven only while a transfer holds it, so idle cycles never write.
    always_comb begin
        bus_rw    = 1'b0;
        bus_len   = 2'd0;
        bus_addr  = 32'd0;
        bus_write = 32'd0;
        if (state_q == ACCESS) begin
            bus_rw    = lat_rw;
            bus_len   = lat_len;
            bus_addr  = lat_addr;
            bus_write = lat_wdata;
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: instance a (ACCESS_CYCLES=1) and instance b (ACCESS_CYCLES=4),
// directed transfers with a per-instance expected queue checked by ack monitors.
module tb_dbus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected ack entry: {master, exc, rdata}
    logic [33:0] exp_a_q[$];
    logic [33:0] exp_b_q[$];
    int ack_a0 = 0, ack_a1 = 0, ack_b0 = 0, ack_b1 = 0;

    logic        a_rst_n, a_m0_req, a_m1_req, a_m0_rw, a_m1_rw;
    logic [1:0]  a_m0_len, a_m1_len, a_bus_len, a_state_dbg;
    logic [31:0] a_m0_addr, a_m1_addr, a_m0_wdata, a_m1_wdata;
    logic        a_m0_ack, a_m1_ack, a_m0_exc, a_m1_exc, a_bus_rw, a_bus_exception, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_write, a_bus_read;

    logic        b_rst_n, b_m0_req, b_m1_req, b_m0_rw, b_m1_rw;
    logic [1:0]  b_m0_len, b_m1_len, b_bus_len, b_state_dbg;
    logic [31:0] b_m0_addr, b_m1_addr, b_m0_wdata, b_m1_wdata;
    logic        b_m0_ack, b_m1_ack, b_m0_exc, b_m1_exc, b_bus_rw, b_bus_exception, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_write, b_bus_read;

    dbus_arbiter #(.ACCESS_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .m0_req(a_m0_req), .m0_rw(a_m0_rw), .m0_len(a_m0_len), .m0_addr(a_m0_addr),
        .m0_wdata(a_m0_wdata), .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata), .m0_exc(a_m0_exc),
        .m1_req(a_m1_req), .m1_rw(a_m1_rw), .m1_len(a_m1_len), .m1_addr(a_m1_addr),
        .m1_wdata(a_m1_wdata), .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata), .m1_exc(a_m1_exc),
        .bus_rw(a_bus_rw), .bus_len(a_bus_len), .bus_addr(a_bus_addr), .bus_write(a_bus_write),
        .bus_read(a_bus_read), .bus_exception(a_bus_exception),
        .busy(a_busy), .state_dbg(a_state_dbg)
    );

    dbus_arbiter #(.ACCESS_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .m0_req(b_m0_req), .m0_rw(b_m0_rw), .m0_len(b_m0_len), .m0_addr(b_m0_addr),
        .m0_wdata(b_m0_wdata), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_exc(b_m0_exc),
        .m1_req(b_m1_req), .m1_rw(b_m1_rw), .m1_len(b_m1_len), .m1_addr(b_m1_addr),
        .m1_wdata(b_m1_wdata), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_exc(b_m1_exc),
        .bus_rw(b_bus_rw), .bus_len(b_bus_len), .bus_addr(b_bus_addr), .bus_write(b_bus_write),
        .bus_read(b_bus_read), .bus_exception(b_bus_exception),
        .busy(b_busy), .state_dbg(b_state_dbg)
    );

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        logic [33:0] e;
        logic [33:0] got;
        if (a_m0_ack || a_m1_ack) begin
            total++;
            got = {a_m1_ack, a_m1_ack ? a_m1_exc : a_m0_exc, a_m1_ack ? a_m1_rdata : a_m0_rdata};
            if (a_m0_ack && a_m1_ack) begin
                bad++;
                $display("FAIL a_ack_overlap: got both acks high, required at most one");
            end else if (exp_a_q.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_ack: got {m,exc,rdata}=%h, required no ack", got);
            end else begin
                e = exp_a_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL a_ack_data: got {m,exc,rdata}=%h, required %h", got, e);
                end
            end
            if (a_m0_ack) ack_a0++;
            if (a_m1_ack) ack_a1++;
        end
    end

    always @(negedge clk) begin
        logic [33:0] e;
        logic [33:0] got;
        if (b_m0_ack || b_m1_ack) begin
            total++;
            got = {b_m1_ack, b_m1_ack ? b_m1_exc : b_m0_exc, b_m1_ack ? b_m1_rdata : b_m0_rdata};
            if (b_m0_ack && b_m1_ack) begin
                bad++;
                $display("FAIL b_ack_overlap: got both acks high, required at most one");
            end else if (exp_b_q.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_ack: got {m,exc,rdata}=%h, required no ack", got);
            end else begin
                e = exp_b_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL b_ack_data: got {m,exc,rdata}=%h, required %h", got, e);
                end
            end
            if (b_m0_ack) ack_b0++;
            if (b_m1_ack) ack_b1++;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic get_ack(input bit sel, input bit m);
        case ({sel, m})
            2'b00:   return a_m0_ack;
            2'b01:   return a_m1_ack;
            2'b10:   return b_m0_ack;
            default: return b_m1_ack;
        endcase
    endfunction

    function automatic logic [66:0] get_bus(input bit sel);
        if (sel) return {b_bus_rw, b_bus_len, b_bus_addr, b_bus_write};
        return {a_bus_rw, a_bus_len, a_bus_addr, a_bus_write};
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? b_busy : a_busy;
    endfunction

    function automatic logic [137:0] get_all(input bit sel);
        if (sel) return {b_m0_ack, b_m1_ack, b_m0_exc, b_m1_exc, b_m0_rdata, b_m1_rdata,
                         get_bus(1'b1), b_busy, b_state_dbg};
        return {a_m0_ack, a_m1_ack, a_m0_exc, a_m1_exc, a_m0_rdata, a_m1_rdata,
                get_bus(1'b0), a_busy, a_state_dbg};
    endfunction

    task automatic check(input string name, input logic [137:0] got, input logic [137:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic set_req(input bit sel, input bit m, input logic v);
        case ({sel, m})
            2'b00:   a_m0_req = v;
            2'b01:   a_m1_req = v;
            2'b10:   b_m0_req = v;
            default: b_m1_req = v;
        endcase
    endtask

    task automatic set_fields(input bit sel, input bit m, input logic rw, input logic [1:0] len,
                              input logic [31:0] addr, input logic [31:0] wdata);
        case ({sel, m})
            2'b00: begin a_m0_rw = rw; a_m0_len = len; a_m0_addr = addr; a_m0_wdata = wdata; end
            2'b01: begin a_m1_rw = rw; a_m1_len = len; a_m1_addr = addr; a_m1_wdata = wdata; end
            2'b10: begin b_m0_rw = rw; b_m0_len = len; b_m0_addr = addr; b_m0_wdata = wdata; end
            default: begin b_m1_rw = rw; b_m1_len = len; b_m1_addr = addr; b_m1_wdata = wdata; end
        endcase
    endtask

    task automatic set_bus(input bit sel, input logic [31:0] rd, input logic ex);
        if (sel) begin b_bus_read = rd; b_bus_exception = ex; end
        else     begin a_bus_read = rd; a_bus_exception = ex; end
    endtask

    task automatic push_exp(input bit sel, input bit m, input logic ex, input logic [31:0] rd);
        if (sel) exp_b_q.push_back({m, ex, rd});
        else     exp_a_q.push_back({m, ex, rd});
    endtask

    // Starts and ends just after a falling edge; reset-state snapshot taken while rst_n is low.
    task automatic do_reset(input bit sel);
        if (sel) b_rst_n = 1'b0; else a_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(sel ? "b_reset_state" : "a_reset_state", get_all(sel), '0);
        if (sel) b_rst_n = 1'b1; else a_rst_n = 1'b1;
    endtask

    // One isolated transfer: bus fields held for ac cycles, bus idle in RESP, ack at ac+2.
    task automatic xfer(input bit sel, input bit m, input logic rw, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input logic ex, input int ac);
        int  n;
        bit  seen;
        set_fields(sel, m, rw, len, addr, wdata);
        set_bus(sel, rd, ex);
        push_exp(sel, m, ex, rd);
        set_req(sel, m, 1'b1);
        @(posedge clk);
        n = 0;
        seen = 0;
        while (!seen && n < ac + 10) begin
            @(negedge clk);
            n++;
            if (get_ack(sel, m)) begin
                seen = 1;
            end else if (n <= ac) begin
                check("bus_hold", {71'd0, get_bus(sel)}, {71'd0, rw, len, addr, wdata});
            end else if (n == ac + 1) begin
                check("bus_idle_resp", {70'd0, get_busy(sel), get_bus(sel)}, {70'd0, 1'b1, 67'd0});
            end
        end
        total++;
        if (!seen || n != ac + 2) begin
            bad++;
            $display("FAIL ack_latency: got %0d cycles (seen=%0d), required %0d", n, seen, ac + 2);
        end
        set_req(sel, m, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int acks;
        int last_cyc;
        int saved;
        bit done;

        a_rst_n = 0; a_m0_req = 0; a_m1_req = 0;
        b_rst_n = 0; b_m0_req = 0; b_m1_req = 0;
        set_fields(0, 0, 0, 0, 0, 0); set_fields(0, 1, 0, 0, 0, 0);
        set_fields(1, 0, 0, 0, 0, 0); set_fields(1, 1, 0, 0, 0, 0);
        set_bus(0, 0, 0); set_bus(1, 0, 0);
        @(negedge clk);

        // ---- instance a, one access cycle ----
        do_reset(0);
        xfer(0, 0, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
        xfer(0, 0, 1'b0, 2'b10, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b1, 1);
        xfer(0, 0, 1'b0, 2'b10, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, 1'b0, 1);
        xfer(0, 1, 1'b0, 2'b01, 32'h0000_0030, 32'h0, 32'h1357_2468, 1'b1, 1);
        check("a_m0_regs_untouched", {105'd0, a_m0_exc, a_m0_rdata}, {105'd0, 1'b0, 32'hCAFE_F00D});

        // Both requesting continuously from reset: m0, m1, m0, m1, three cycles apart.
        do_reset(0);
        set_fields(0, 0, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        set_fields(0, 1, 1'b0, 2'b10, 32'h0000_0200, 32'h0);
        set_bus(0, 32'h1111_2222, 1'b0);
        push_exp(0, 0, 0, 32'h1111_2222); push_exp(0, 1, 0, 32'h1111_2222);
        push_exp(0, 0, 0, 32'h1111_2222); push_exp(0, 1, 0, 32'h1111_2222);
        a_m0_req = 1; a_m1_req = 1;
        @(posedge clk);
        n = 0; acks = 0; last_cyc = 0; done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (a_m0_ack || a_m1_ack) begin
                acks++;
                check("rr_ack_spacing", 138'(n - last_cyc), 138'(3));
                last_cyc = n;
                if (acks == 4) begin
                    a_m0_req = 0; a_m1_req = 0;
                    done = 1;
                end
            end
        end
        check("rr_ack_count", 138'(acks), 138'(4));

        // Address change after grant is ignored; m1 dropping req before grant is never acked.
        do_reset(0);
        saved = ack_a1;
        set_fields(0, 0, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        set_fields(0, 1, 1'b0, 2'b10, 32'h0000_0300, 32'h0);
        set_bus(0, 32'h7777_8888, 1'b0);
        push_exp(0, 0, 0, 32'h7777_8888);
        a_m0_req = 1; a_m1_req = 1;
        @(posedge clk);
        #1;
        a_m0_addr = 32'h0000_0200;
        a_m1_req = 0;
        @(negedge clk);
        check("a_bus_addr_latched", {106'd0, a_bus_addr}, {106'd0, 32'h0000_0100});
        n = 1;
        while (!a_m0_ack && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("a_m0_ack_after_addr_change", {104'd0, 1'b0, a_m0_ack, 32'(n)}, {104'd0, 1'b0, 1'b1, 32'd3});
        a_m0_req = 0;
        repeat (6) @(negedge clk);
        check("a_no_m1_ack", 138'(ack_a1 - saved), 138'(0));

        // ---- instance b, four access cycles ----
        do_reset(1);
        xfer(1, 1, 1'b1, 2'b10, 32'hF000_0000, 32'h0000_00A5, 32'h55AA_55AA, 1'b0, 4);

        // Reset during the second ACCESS cycle aborts with no ack.
        saved = ack_b0;
        set_fields(1, 0, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
        set_bus(1, 32'h0BAD_F00D, 1'b0);
        b_m0_req = 1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        b_rst_n = 0;
        b_m0_req = 0;
        @(negedge clk);
        check("b_reset_mid_access", get_all(1), '0);
        b_rst_n = 1;
        repeat (8) @(negedge clk);
        check("b_no_ack_after_abort", 138'(ack_b0 - saved), 138'(0));
        xfer(1, 0, 1'b0, 2'b10, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 1'b0, 4);

        repeat (3) @(negedge clk);
        check("a_queue_drained", 138'(exp_a_q.size()), 138'(0));
        check("b_queue_drained", 138'(exp_b_q.size()), 138'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 1, meaning bus cycles held per transfer, legal range 1..15.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; one clock, all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset; synchronous, active-low.
REQ-004 SHALL have ports m0_req and m1_req, input, 1 each, meaning access request; m0 is the core load/store unit and m1 is the loader/debug port.
REQ-005 SHALL have ports m0_rw and m1_rw, input, 1 each, meaning 1=write, 0=read.
REQ-006 SHALL have ports m0_len and m1_len, input, 2 each, meaning access size code, passed through unmodified.
REQ-007 SHALL have ports m0_addr, m1_addr, m0_wdata and m1_wdata, input, 32 each, meaning address and write data.
REQ-008 SHALL have ports m0_ack and m1_ack, output, 1 each, meaning a one-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata and m1_rdata, output, 32 each, meaning captured read data.
REQ-010 SHALL have ports m0_exc and m1_exc, output, 1 each, meaning captured bus exception, valid with ack.
REQ-011 SHALL have ports bus_rw, bus_len, bus_addr and bus_write, output, 1/2/32/32, meaning signals that drive the data bus.
REQ-012 SHALL have ports bus_read and bus_exception, input, 32/1, meaning returns from the data bus.
REQ-013 SHALL have port busy, output, 1, meaning high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, ACCESS and RESP.
REQ-015 IDLE: if any req is high, the block SHALL latch the winner's rw, len, addr and wdata, load cnt=ACCESS_CYCLES-1 and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both requesting, the master not granted last wins; after reset, m0 has priority.
REQ-017 ACCESS: bus outputs SHALL equal the latched values, stable for every ACCESS cycle. While cnt>0, cnt SHALL decrement; at cnt==0 the block SHALL capture bus_read and bus_exception into the granted master's rdata/exc registers and go to RESP.
REQ-018 RESP: the block SHALL assert the granted master's ack for exactly one cycle, record that master as last-granted and go to IDLE.
REQ-019 Outside ACCESS, bus_rw SHALL be 0 and bus_addr, bus_write and bus_len SHALL be 0, so no spurious writes reach the LED register or RAM.
REQ-020 Latency from req sampled in IDLE to ack SHALL be ACCESS_CYCLES+2 cycles; back-to-back throughput SHALL be one transfer per ACCESS_CYCLES+2 cycles.
REQ-021 Requesters SHALL hold req and request fields stable until ack; the arbiter SHALL ignore field changes after latching.
REQ-022 If req is still high in the cycle after ack, it SHALL be treated as a new request.
REQ-023 A req that drops before grant SHALL be dropped silently; a req that drops after grant SHALL not abort the transfer, and ack SHALL still be issued.
REQ-024 rdata and exc SHALL hold their last captured value until that master's next completion; the other master's registers SHALL be untouched.
REQ-025 At most one ack SHALL be high in any cycle; the two acks SHALL never be high simultaneously.
REQ-026 On a write, rdata SHALL still capture bus_read, and exc SHALL be valid for writes too.

Reset
REQ-027 While rst_n is 0 at a clock edge, the block SHALL set state=IDLE, cnt=0, last-granted=m1 (so m0 wins first), both acks 0, both rdata 0, both exc 0, all bus outputs 0 and busy 0.
REQ-028 A reset asserted mid-ACCESS or in RESP SHALL abort the transfer with no ack issued; bus_rw SHALL be 0 from the next cycle.

Verification
REQ-029 Reset, then m0 read at addr 0x00000010 with bus_read=0xDEADBEEF and ACCESS_CYCLES=1 -> m0_ack high exactly at cycle 3, m0_rdata=0xDEADBEEF, m0_exc=0.
REQ-030 m0 and m1 both requesting continuously from reset -> grants alternate m0, m1, m0, m1, with acks 3 cycles apart and never overlapping.
REQ-031 ACCESS_CYCLES=4, m1 write 0x000000A5 to the LED address -> bus_rw=1 with stable bus_addr/bus_write for exactly 4 cycles, then m1_ack at cycle 6.
REQ-032 Read with bus_exception=1 -> exc=1 together with ack; the next clean access -> exc=0.
REQ-033 rst_n driven low during the second ACCESS cycle -> no ack, all outputs 0 the next cycle, and a fresh m0 request afterwards completes normally.
REQ-034 m0 request changes addr after grant, and m1 drops req before grant -> bus_addr keeps the latched value and no m1_ack occurs.
